// File: rtl/serial_receiver_pkg.sv
// -----------------------------------------------------------------------------
// serial_receiver_pkg
// Shared constants and state encodings for the tracker UART receive path.
// The packet layout is a sync byte, PAYLOAD_BYTES payload bytes and one
// checksum byte. The payload carries a SENSOR_WIDTH-bit word, LSB byte first.
// -----------------------------------------------------------------------------
package serial_receiver_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         PAYLOAD_BYTES = 13;
    localparam int         SENSOR_WIDTH  = 102;
    localparam int         BUF_WIDTH     = 8 * PAYLOAD_BYTES;

    // Packet-level FSM
    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } pkt_state_t;

    // Byte-level receiver FSM
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/serial_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_receiver_if
// Line and result signals of the tracker UART receiver.
//   rx                 serial line, idle high (driven by the line side)
//   sensor_iterations  last valid packet payload
//   data_valid         1-cycle pulse, new sensor_iterations present
//   frame_error        1-cycle pulse, bad stop bit, padding or timeout
//   checksum_error     1-cycle pulse, checksum mismatch
//   busy               packet collection in progress
// slave  : the receiver (samples rx, drives results)
// master : the line side / consumer (drives rx, observes results)
// -----------------------------------------------------------------------------
interface serial_receiver_if;
    import serial_receiver_pkg::*;

    logic                    rx;
    logic [SENSOR_WIDTH-1:0] sensor_iterations;
    logic                    data_valid;
    logic                    frame_error;
    logic                    checksum_error;
    logic                    busy;

    modport slave (
        input  rx,
        output sensor_iterations, data_valid, frame_error, checksum_error, busy
    );

    modport master (
        output rx,
        input  sensor_iterations, data_valid, frame_error, checksum_error, busy
    );

endinterface

// File: rtl/serial_receiver_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 byte deserialiser: two-flop synchroniser, start-bit glitch rejection
// at the half-bit point, data and stop bits sampled at bit centres.
//   clk_12MHz   clock
//   rst         asynchronous active-high reset
//   rx          raw serial line
//   byte_valid  1-cycle pulse, rx_byte holds a byte with a good stop bit
//   byte_ferr   1-cycle pulse, stop bit sampled low
//   rx_byte     last received byte
// -----------------------------------------------------------------------------
module uart_rx_byte
    import serial_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_12MHz,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic       byte_ferr,
    output logic [7:0] rx_byte
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state, state_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;

    // The start bit is resampled half a bit in; every later sample is a full bit on.
    assign tick = (clk_cnt == ((state == RX_START) ? HALF_LAST : BIT_LAST));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is inferred.
        state_next = state;
        case (state)
            RX_IDLE:      if (!rx_sync) state_next = RX_START;
            RX_START:     if (tick) state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (tick && bit_idx == 3'd7) state_next = RX_STOP;
            RX_STOP:      if (tick) state_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) state_next = RX_IDLE;
            default:      state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_12MHz or posedge rst) begin
        if (rst) begin
            // Synchroniser flops reset to the idle line level so reset release is not seen as a start bit.
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            byte_ferr  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            state      <= state_next;
            byte_valid <= 1'b0;
            byte_ferr  <= 1'b0;

            if (tick || state == RX_IDLE || state == RX_WAIT_HIGH)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;

            if (state == RX_START)
                bit_idx <= '0;
            else if (state == RX_DATA && tick) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end

            if (state == RX_STOP && tick) begin
                rx_byte    <= shift;
                byte_valid <= rx_sync;
                byte_ferr  <= !rx_sync;
            end
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
// Reassembles framed tracker packets (sync, 13 payload bytes, XOR checksum)
// into the 102-bit sensor_iterations word.
//   clk_12MHz  clock
//   rst        asynchronous active-high reset
//   bus        serial_receiver_if.slave: rx in; sensor_iterations, data_valid,
//              frame_error, checksum_error, busy out
// -----------------------------------------------------------------------------
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 16 * CLKS_PER_BIT
) (
    input  logic               clk_12MHz,
    input  logic               rst,
    serial_receiver_if.slave   bus
);

    localparam int             TO_W      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [3:0]     LAST_IDX  = 4'(PAYLOAD_BYTES - 1);

    logic                    byte_valid, byte_ferr;
    logic [7:0]              rx_byte;

    pkt_state_t              state, state_next;
    logic [3:0]              idx;
    logic [7:0]              xor_acc;
    logic [BUF_WIDTH-1:0]    shift_buf;
    logic [TO_W-1:0]         timeout_cnt;
    logic                    timeout_hit;
    logic [SENSOR_WIDTH-1:0] sensor_q;
    logic                    dv_q, fe_q, ce_q;
    logic                    dv_next, fe_next, ce_next;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_12MHz  (clk_12MHz),
        .rst        (rst),
        .rx         (bus.rx),
        .byte_valid (byte_valid),
        .byte_ferr  (byte_ferr),
        .rx_byte    (rx_byte)
    );

    // Counts cycles since the last completed byte while a packet is open.
    assign timeout_hit = (state != HUNT) && !byte_valid && (timeout_cnt == TO_LAST);

    always_comb begin
        state_next = state;
        dv_next    = 1'b0;
        fe_next    = 1'b0;
        ce_next    = 1'b0;
        case (state)
            HUNT: begin
                // Non-sync bytes and framing errors are ignored while hunting.
                if (byte_valid && rx_byte == SYNC_BYTE)
                    state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (byte_ferr || timeout_hit) begin
                    fe_next    = 1'b1;
                    state_next = HUNT;
                end else if (byte_valid && idx == LAST_IDX) begin
                    if (rx_byte[7:6] != 2'b00) begin
                        fe_next    = 1'b1;
                        state_next = HUNT;
                    end else
                        state_next = CHECK;
                end
            end
            CHECK: begin
                if (byte_ferr || timeout_hit) begin
                    fe_next    = 1'b1;
                    state_next = HUNT;
                end else if (byte_valid) begin
                    dv_next    = (rx_byte == xor_acc);
                    ce_next    = (rx_byte != xor_acc);
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk_12MHz or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            idx         <= '0;
            xor_acc     <= '0;
            shift_buf   <= '0;
            timeout_cnt <= '0;
            sensor_q    <= '0;
            dv_q        <= 1'b0;
            fe_q        <= 1'b0;
            ce_q        <= 1'b0;
        end else begin
            state <= state_next;
            dv_q  <= dv_next;
            fe_q  <= fe_next;
            ce_q  <= ce_next;

            if (state == HUNT || byte_valid)
                timeout_cnt <= '0;
            else if (!timeout_hit)
                timeout_cnt <= timeout_cnt + 1'b1;

            if (state == HUNT) begin
                idx     <= '0;
                xor_acc <= '0;
            end else if (state == PAYLOAD && byte_valid) begin
                // Bytes enter at the top; after 13 shifts payload byte 0 sits at [7:0].
                shift_buf <= {rx_byte, shift_buf[BUF_WIDTH-1:8]};
                xor_acc   <= xor_acc ^ rx_byte;
                idx       <= idx + 1'b1;
            end

            // Padding bits [103:102] are known zero by the time CHECK is reached.
            if (dv_next)
                sensor_q <= SENSOR_WIDTH'(shift_buf);
        end
    end

    assign bus.sensor_iterations = sensor_q;
    assign bus.data_valid        = dv_q;
    assign bus.frame_error       = fe_q;
    assign bus.checksum_error    = ce_q;
    assign bus.busy              = (state != HUNT);

endmodule

// File: tb/tb_serial_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_receiver
// Directed bench for serial_receiver: drives 8N1 frames on rx and checks the
// packet-level pulses and the held sensor_iterations word.
// -----------------------------------------------------------------------------
module tb_serial_receiver;
    import serial_receiver_pkg::*;

    localparam int CPB = 32;
    localparam int TO  = 16 * CPB;

    typedef logic [7:0] pkt_t [15];

    logic clk_12MHz = 1'b0;
    logic rst       = 1'b1;

    serial_receiver_if bus ();

    serial_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk_12MHz (clk_12MHz),
        .rst       (rst),
        .bus       (bus.slave)
    );

    always #42 clk_12MHz = ~clk_12MHz;

    int checks   = 0;
    int failures = 0;
    int dv_cnt   = 0;
    int fe_cnt   = 0;
    int ce_cnt   = 0;
    int multi    = 0;
    int dv0, fe0, ce0;
    logic [SENSOR_WIDTH-1:0] exp_value = '0;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk_12MHz) begin
        if (!rst) begin
            if (bus.data_valid)     dv_cnt++;
            if (bus.frame_error)    fe_cnt++;
            if (bus.checksum_error) ce_cnt++;
            if (int'(bus.data_valid) + int'(bus.frame_error) + int'(bus.checksum_error) > 1)
                multi++;
        end
    end

    task automatic snap();
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        ce0 = ce_cnt;
    endtask

    task automatic send_bit(input logic v);
        bus.rx = v;
        repeat (CPB) @(negedge clk_12MHz);
    endtask

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        repeat (n * CPB) @(negedge clk_12MHz);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic make_packet(input logic [SENSOR_WIDTH-1:0] p, output pkt_t pk);
        logic [BUF_WIDTH-1:0] w;
        w     = {2'b00, p};
        pk[0] = SYNC_BYTE;
        pk[14] = 8'h00;
        for (int k = 0; k < 13; k++) begin
            pk[k+1] = w[8*k +: 8];
            pk[14]  = pk[14] ^ pk[k+1];
        end
    endtask

    task automatic send_packet(input pkt_t pk);
        for (int i = 0; i < 15; i++) send_byte(pk[i], 1'b1);
    endtask

    task automatic expect_deltas(input string name, input int dv, input int fe, input int ce);
        checks++;
        if (dv_cnt - dv0 !== dv) begin
            failures++;
            $display("FAIL %s data_valid pulses: got %0d expected %0d", name, dv_cnt - dv0, dv);
        end
        checks++;
        if (fe_cnt - fe0 !== fe) begin
            failures++;
            $display("FAIL %s frame_error pulses: got %0d expected %0d", name, fe_cnt - fe0, fe);
        end
        checks++;
        if (ce_cnt - ce0 !== ce) begin
            failures++;
            $display("FAIL %s checksum_error pulses: got %0d expected %0d", name, ce_cnt - ce0, ce);
        end
    endtask

    task automatic expect_value(input string name);
        checks++;
        if (bus.sensor_iterations !== exp_value) begin
            failures++;
            $display("FAIL %s sensor_iterations: got %h expected %h", name, bus.sensor_iterations, exp_value);
        end
    endtask

    task automatic expect_busy(input string name, input logic b);
        checks++;
        if (bus.busy !== b) begin
            failures++;
            $display("FAIL %s busy: got %b expected %b", name, bus.busy, b);
        end
    endtask

    task automatic expect_all_zero(input string name);
        checks++;
        if ({bus.data_valid, bus.frame_error, bus.checksum_error, bus.busy} !== 4'b0000) begin
            failures++;
            $display("FAIL %s flags {dv,fe,ce,busy}: got %b expected 0000", name,
                     {bus.data_valid, bus.frame_error, bus.checksum_error, bus.busy});
        end
        checks++;
        if (bus.sensor_iterations !== '0) begin
            failures++;
            $display("FAIL %s sensor_iterations: got %h expected 0", name, bus.sensor_iterations);
        end
    endtask

    task automatic test_reset();
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (5) @(negedge clk_12MHz);
        expect_all_zero("reset");
        rst = 1'b0;
        idle_bits(2);
        expect_busy("reset_release", 1'b0);
    endtask

    task automatic test_good_packet();
        pkt_t pk;
        logic [SENSOR_WIDTH-1:0] p;
        p = 102'h2_0000_0000_0000_0000_0000_0001;
        make_packet(p, pk);
        snap();
        send_packet(pk);
        idle_bits(2);
        exp_value = p;
        expect_deltas("good", 1, 0, 0);
        expect_value("good");
    endtask

    task automatic test_bad_checksum();
        pkt_t pk;
        logic [SENSOR_WIDTH-1:0] pl [2];
        pl[0] = 102'h2_0000_0000_0000_0000_0000_0001;
        pl[1] = 102'h3_1234_5678_9abc_def0_1357_2468;
        for (int i = 0; i < 2; i++) begin
            make_packet(pl[i], pk);
            pk[14] = pk[14] ^ 8'h01;
            snap();
            send_packet(pk);
            idle_bits(2);
            expect_deltas("bad_checksum", 0, 0, 1);
            expect_value("bad_checksum");
        end
    endtask

    task automatic test_stop_error();
        pkt_t pk;
        logic [SENSOR_WIDTH-1:0] p;
        p = 102'h1_0f0e_0d0c_0b0a_0908_0706_0504;
        make_packet(p, pk);
        snap();
        for (int i = 0; i < 6; i++) send_byte(pk[i], 1'b1);
        send_byte(pk[6], 1'b0);   // payload byte 5 with low stop bit
        idle_bits(3);
        expect_deltas("stop_error", 0, 1, 0);
        expect_busy("stop_error", 1'b0);
        expect_value("stop_error");
        snap();
        send_packet(pk);
        idle_bits(2);
        exp_value = p;
        expect_deltas("after_stop_error", 1, 0, 0);
        expect_value("after_stop_error");
    endtask

    task automatic test_timeout();
        pkt_t pk;
        make_packet(102'h0_aaaa_bbbb_cccc_dddd_eeee_ffff, pk);
        snap();
        for (int i = 0; i < 7; i++) send_byte(pk[i], 1'b1);
        idle_bits(8);             // well inside the timeout window
        expect_busy("timeout_open", 1'b1);
        expect_deltas("timeout_open", 0, 0, 0);
        idle_bits(12);            // 20 bit times of idle in total
        expect_deltas("timeout", 0, 1, 0);
        expect_busy("timeout", 1'b0);
        expect_value("timeout");
    endtask

    task automatic test_padding();
        pkt_t pk;
        make_packet(102'h0_1111_2222_3333_4444_5555_6666, pk);
        pk[13] = pk[13] | 8'hC0;
        pk[14] = pk[14] ^ 8'hC0;  // checksum still consistent; only padding is bad
        snap();
        send_packet(pk);
        idle_bits(2);
        expect_deltas("padding", 0, 1, 0);
        expect_value("padding");
    endtask

    task automatic test_garbage_glitch();
        pkt_t pk;
        logic [SENSOR_WIDTH-1:0] p;
        p = 102'h0_00a5_a5a5_0000_1111_a500_00a5;
        snap();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle_bits(2);
        bus.rx = 1'b0;
        repeat (10) @(negedge clk_12MHz);
        idle_bits(3);
        expect_busy("garbage", 1'b0);
        make_packet(p, pk);
        send_packet(pk);
        idle_bits(2);
        exp_value = p;
        expect_deltas("garbage_glitch", 1, 0, 0);
        expect_value("garbage_glitch");
    endtask

    task automatic test_rst_mid_packet();
        pkt_t pk;
        logic [SENSOR_WIDTH-1:0] p;
        p = 102'h3_fedc_ba98_7654_3210_0123_4567;
        make_packet(p, pk);
        snap();
        for (int i = 0; i < 9; i++) send_byte(pk[i], 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(pk[9][i]);
        expect_busy("rst_pre", 1'b1);
        rst = 1'b1;
        #1;
        expect_all_zero("rst_mid");
        bus.rx = 1'b1;
        repeat (4) @(negedge clk_12MHz);
        rst = 1'b0;
        idle_bits(3);
        exp_value = '0;
        expect_deltas("rst_mid", 0, 0, 0);
        expect_value("rst_mid");
        snap();
        send_packet(pk);
        idle_bits(2);
        exp_value = p;
        expect_deltas("after_rst", 1, 0, 0);
        expect_value("after_rst");
    endtask

    task automatic test_back_to_back();
        pkt_t pa, pb;
        logic [SENSOR_WIDTH-1:0] p2;
        p2 = 102'h2_5a5a_5a5a_c3c3_c3c3_8001_7ffe;
        make_packet(102'h1_0000_ffff_0000_ffff_0000_ffff, pa);
        make_packet(p2, pb);
        snap();
        send_packet(pa);
        send_packet(pb);
        idle_bits(2);
        exp_value = p2;
        expect_deltas("back_to_back", 2, 0, 0);
        expect_value("back_to_back");
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_good_packet();
        test_bad_checksum();
        test_stop_error();
        test_timeout();
        test_padding();
        test_garbage_glitch();
        test_rst_mid_packet();
        test_back_to_back();
        checks++;
        if (multi !== 0) begin
            failures++;
            $display("FAIL one_hot_pulses: got %0d overlapping cycles expected 0", multi);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
